alu_arbiter: RTL

//  Shares the single combinational ALU between two requesters (0: execute stage, 1: address/branch unit).

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_arb_rr_pick.sv | 33 +++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode and arbiter state types, used by the ALU decoder, the control unit and alu_arbiter.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOR = 3'd4,
    OP_XOR = 3'd5,
    OP_DIV = 3'd6,
    OP_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // True when the registered op is a divide whose divisor is zero.
  function automatic logic is_div_by_zero(input logic [2:0] op, input logic b_is_zero);
    return (op == 3'(OP_DIV)) && b_is_zero;
  endfunction

endpackage

// File: rtl/alu_arb_rr_pick.sv
// Combinational 2-way round-robin picker: a lone valid wins outright, a tie goes to rr_ptr_i.
module alu_arb_rr_pick (
  input  logic [1:0] req_valid_i,
  input  logic       rr_ptr_i,
  output logic [1:0] grant_o,
  output logic       gnt_id_o
);

  // Grant selection.
  always_comb begin
    grant_o  = 2'b00;
    gnt_id_o = 1'b0;
    case (req_valid_i)
      2'b01: begin
        grant_o  = 2'b01;
        gnt_id_o = 1'b0;
      end
      2'b10: begin
        grant_o  = 2'b10;
        gnt_id_o = 1'b1;
      end
      2'b11: begin
        grant_o  = rr_ptr_i ? 2'b10 : 2'b01;
        gnt_id_o = rr_ptr_i;
      end
      default: begin
        grant_o  = 2'b00;
        gnt_id_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between execute stage (0) and address/branch unit (1).
// Optional macro ALU_ARB_DIVZERO_TRAP_EN: divide-by-zero returns all ones with resp_err set.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic [1:0][2:0]       req_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_op,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_zero,
  output logic                  resp_err
);

  arb_state_t       state_q, state_d;
  logic             rr_ptr_q;
  logic [1:0]       grant_s;
  logic             gnt_id_s;
  logic             hs_s;
  logic             trap_s;
  logic [WIDTH-1:0] cap_result_s;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;
  logic             resp_valid_q, resp_id_q, resp_zero_q, resp_err_q;
  logic [WIDTH-1:0] resp_result_q;

  alu_arb_rr_pick u_rr_pick (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant_s),
    .gnt_id_o    (gnt_id_s)
  );

  assign hs_s = |(req_valid & req_ready);

`ifdef ALU_ARB_DIVZERO_TRAP_EN
  assign trap_s = is_div_by_zero(alu_op_q, alu_b_q == {WIDTH{1'b0}});
`else
  assign trap_s = 1'b0;
`endif
  assign cap_result_s = trap_s ? {WIDTH{1'b1}} : alu_result;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = hs_s ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    state_d = (resp_valid_q && resp_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Accept only while idle; the picker already limits the grant to one requester.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE) req_ready = grant_s;
    else                 req_ready = 2'b00;
  end

  // Operand latch on grant, result capture after the ALU has settled for a full cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= 1'b0;
      alu_a_q       <= {WIDTH{1'b0}};
      alu_b_q       <= {WIDTH{1'b0}};
      alu_op_q      <= 3'b000;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= {WIDTH{1'b0}};
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && hs_s) begin
        alu_a_q   <= req_a[gnt_id_s];
        alu_b_q   <= req_b[gnt_id_s];
        alu_op_q  <= req_op[gnt_id_s];
        resp_id_q <= gnt_id_s;
        rr_ptr_q  <= ~gnt_id_s;
      end
      if (state_q == EXEC) begin
        resp_valid_q  <= 1'b1;
        resp_result_q <= cap_result_s;
        resp_zero_q   <= trap_s ? 1'b0 : alu_zero;
        resp_err_q    <= trap_s;
      end else if (state_q == RESP && resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;

endmodule
